mastermind_core: RTL and testbench

- Parametrised game engine for the Mastermind board design.
- Owns guess entry (cursor and colour per peg), turn history storage, sequential feedback scoring and the win/lose state machine.
- Consumes debounced one-cycle button pulses and a secret code from the PRNG.
- Drives guess colours to the LED driver, and history and feedback to the SSD/turn display path.

---
 rtl/mastermind_core.sv | 225 ++++++++++++++++++++++
 tb/tb_mastermind_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_core.sv
// rtl/mastermind_core.sv - Mastermind game engine: guess entry, turn history, sequential scoring, win/lose FSM
module mastermind_core #(
  parameter int N_PEGS    = 4,
  parameter int COLOR_W   = 3,
  parameter int MAX_TURNS = 8,
  localparam int GW     = N_PEGS * COLOR_W,
  localparam int CUR_W  = $clog2(N_PEGS),
  localparam int CNT_W  = $clog2(N_PEGS + 1),
  localparam int TURN_W = $clog2(MAX_TURNS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              btn_select,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              code_valid,
  input  logic [GW-1:0]     code_in,
  output logic [GW-1:0]     guess_out,
  output logic [CUR_W-1:0]  cursor,
  output logic [TURN_W-1:0] hist_sel,
  output logic [GW-1:0]     hist_guess,
  output logic [CNT_W-1:0]  hist_exact,
  output logic [CNT_W-1:0]  hist_partial,
  output logic [TURN_W-1:0] turn_count,
  output logic              busy,
  output logic              game_over,
  output logic              win
);

  localparam int N_COLORS = 2 ** COLOR_W;
  localparam int SC_W     = COLOR_W + 1;
  localparam int IDX_W    = (MAX_TURNS > 1) ? $clog2(MAX_TURNS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_SCORE, S_WIN, S_LOSE} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       code_q, code_d, guess_q, guess_d, guess_stepped;
  logic [CUR_W-1:0]    cursor_q, cursor_d;
  logic [TURN_W-1:0]   hist_sel_q, hist_sel_d, turn_q, turn_d;
  logic [SC_W-1:0]     score_cnt_q, score_cnt_d;
  logic [CNT_W-1:0]    exact_q, exact_d, total_q, total_d;
  logic [CNT_W-1:0]    exact_now, code_cnt, guess_cnt, min_cnt, total_next, partial_now;
  logic [COLOR_W-1:0]  cur_color;
  logic                score_last, hist_wr_guess, hist_wr_fb, hist_clr;
  logic [IDX_W-1:0]    wr_idx, rd_idx;

  logic [GW-1:0]       hist_guess_q   [MAX_TURNS];
  logic [CNT_W-1:0]    hist_exact_q   [MAX_TURNS];
  logic [CNT_W-1:0]    hist_partial_q [MAX_TURNS];

  // Score counter 0 clears/computes exact; counts 1..N_COLORS handle colour count-1.
  assign cur_color  = COLOR_W'(score_cnt_q - SC_W'(1));
  assign score_last = (score_cnt_q == SC_W'(N_COLORS));
  assign wr_idx     = IDX_W'(turn_q);
  assign rd_idx     = IDX_W'(hist_sel_q);

  always_comb begin
    exact_now = '0;
    code_cnt  = '0;
    guess_cnt = '0;
    for (int p = 0; p < N_PEGS; p++) begin
      if (code_q[p*COLOR_W +: COLOR_W] == guess_q[p*COLOR_W +: COLOR_W])
        exact_now = exact_now + CNT_W'(1);
      if (code_q[p*COLOR_W +: COLOR_W] == cur_color)
        code_cnt = code_cnt + CNT_W'(1);
      if (guess_q[p*COLOR_W +: COLOR_W] == cur_color)
        guess_cnt = guess_cnt + CNT_W'(1);
    end
    min_cnt     = (code_cnt < guess_cnt) ? code_cnt : guess_cnt;
    total_next  = total_q + min_cnt;
    partial_now = total_next - exact_q;
  end

  always_comb begin
    guess_stepped = guess_q;
    for (int p = 0; p < N_PEGS; p++) begin
      if (cursor_q == CUR_W'(p))
        guess_stepped[p*COLOR_W +: COLOR_W] = btn_up ?
          guess_q[p*COLOR_W +: COLOR_W] + COLOR_W'(1) :
          guess_q[p*COLOR_W +: COLOR_W] - COLOR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (code_valid) state_d = S_ENTRY;
      S_ENTRY: if (!mode && btn_select) state_d = S_SCORE;
      S_SCORE: begin
        if (score_last) begin
          if (exact_q == CNT_W'(N_PEGS))                      state_d = S_WIN;
          else if (turn_q + TURN_W'(1) == TURN_W'(MAX_TURNS)) state_d = S_LOSE;
          else                                                state_d = S_ENTRY;
        end
      end
      S_WIN, S_LOSE: if (btn_select) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_SCORE);
    game_over = (state_q == S_WIN) || (state_q == S_LOSE);
    win       = (state_q == S_WIN);
  end

  always_comb begin
    code_d        = code_q;
    guess_d       = guess_q;
    cursor_d      = cursor_q;
    hist_sel_d    = hist_sel_q;
    turn_d        = turn_q;
    score_cnt_d   = score_cnt_q;
    exact_d       = exact_q;
    total_d       = total_q;
    hist_wr_guess = 1'b0;
    hist_wr_fb    = 1'b0;
    hist_clr      = 1'b0;

    if (mode && state_q != S_IDLE) begin
      if (btn_up) begin
        if (hist_sel_q + TURN_W'(1) < turn_q) hist_sel_d = hist_sel_q + TURN_W'(1);
      end else if (btn_down) begin
        if (hist_sel_q != '0) hist_sel_d = hist_sel_q - TURN_W'(1);
      end
    end

    case (state_q)
      S_IDLE: if (code_valid) code_d = code_in;
      S_ENTRY: begin
        if (!mode) begin
          if (btn_select) begin
            hist_wr_guess = 1'b1;
            score_cnt_d   = '0;
          end else if (btn_left) begin
            cursor_d = (cursor_q == '0) ? CUR_W'(N_PEGS - 1) : cursor_q - CUR_W'(1);
          end else if (btn_right) begin
            cursor_d = (cursor_q == CUR_W'(N_PEGS - 1)) ? '0 : cursor_q + CUR_W'(1);
          end else if (btn_up || btn_down) begin
            guess_d = guess_stepped;
          end
        end
      end
      S_SCORE: begin
        score_cnt_d = score_cnt_q + SC_W'(1);
        if (score_cnt_q == '0) begin
          exact_d = exact_now;
          total_d = '0;
        end else begin
          total_d = total_next;
        end
        if (score_last) begin
          hist_wr_fb = 1'b1;
          turn_d     = turn_q + TURN_W'(1);
          hist_sel_d = turn_q;
        end
      end
      S_WIN, S_LOSE: begin
        if (btn_select) begin
          hist_clr   = 1'b1;
          guess_d    = '0;
          cursor_d   = '0;
          hist_sel_d = '0;
          turn_d     = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q      <= '0;
      guess_q     <= '0;
      cursor_q    <= '0;
      hist_sel_q  <= '0;
      turn_q      <= '0;
      score_cnt_q <= '0;
      exact_q     <= '0;
      total_q     <= '0;
    end else begin
      code_q      <= code_d;
      guess_q     <= guess_d;
      cursor_q    <= cursor_d;
      hist_sel_q  <= hist_sel_d;
      turn_q      <= turn_d;
      score_cnt_q <= score_cnt_d;
      exact_q     <= exact_d;
      total_q     <= total_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || hist_clr) begin
      for (int t = 0; t < MAX_TURNS; t++) begin
        hist_guess_q[t]   <= '0;
        hist_exact_q[t]   <= '0;
        hist_partial_q[t] <= '0;
      end
    end else begin
      if (hist_wr_guess) hist_guess_q[wr_idx] <= guess_q;
      if (hist_wr_fb) begin
        hist_exact_q[wr_idx]   <= exact_q;
        hist_partial_q[wr_idx] <= partial_now;
      end
    end
  end

  assign guess_out    = guess_q;
  assign cursor       = cursor_q;
  assign hist_sel     = hist_sel_q;
  assign turn_count   = turn_q;
  assign hist_guess   = hist_guess_q[rd_idx];
  assign hist_exact   = hist_exact_q[rd_idx];
  assign hist_partial = hist_partial_q[rd_idx];

endmodule

// File: tb/tb_mastermind_core.sv
// tb/tb_mastermind_core.sv - self-checking bench for mastermind_core with a peg-matching reference model
module tb_mastermind_core;

  localparam int NP = 4, CW = 3, MT = 8, NC = 8;
  localparam int GW = NP * CW, CUR_W = 2, CNT_W = 3, TURN_W = 4;

  logic clk = 1'b0, rst = 1'b1, mode = 1'b0;
  logic btn_select = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic code_valid = 1'b0;
  logic [GW-1:0] code_in = '0;
  logic [GW-1:0] guess_out, hist_guess;
  logic [CUR_W-1:0] cursor;
  logic [TURN_W-1:0] hist_sel, turn_count;
  logic [CNT_W-1:0] hist_exact, hist_partial;
  logic busy, game_over, win;

  mastermind_core #(.N_PEGS(NP), .COLOR_W(CW), .MAX_TURNS(MT)) u_dut (
    .clk(clk), .rst(rst), .mode(mode),
    .btn_select(btn_select), .btn_left(btn_left), .btn_right(btn_right),
    .btn_up(btn_up), .btn_down(btn_down),
    .code_valid(code_valid), .code_in(code_in),
    .guess_out(guess_out), .cursor(cursor), .hist_sel(hist_sel),
    .hist_guess(hist_guess), .hist_exact(hist_exact), .hist_partial(hist_partial),
    .turn_count(turn_count), .busy(busy), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  int m_code [NP];
  int m_guess[NP];
  int h_g[MT], h_e[MT], h_p[MT];
  int m_cursor, m_turn, m_hsel;
  bit m_idle, m_over, m_win;

  typedef struct {
    bit            fresh;
    logic [GW-1:0] code;
    logic [GW-1:0] guess;
    int            ex;
    int            pa;
    bit            won;
  } vec_t;
  vec_t vt[7];

  function automatic logic [GW-1:0] pk(input int a, input int b, input int c, input int d);
    return {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  function automatic int packg();
    int v = 0;
    for (int p = 0; p < NP; p++) v |= m_guess[p] << (CW * p);
    return v;
  endfunction

  // Greedy peg matching: exact hits first, then pair each leftover guess peg with an unused code peg.
  task automatic score(output int e, output int pt);
    bit cu[NP], gu[NP];
    bit found;
    e = 0; pt = 0;
    for (int p = 0; p < NP; p++) begin
      cu[p] = (m_code[p] == m_guess[p]);
      gu[p] = cu[p];
      if (cu[p]) e++;
    end
    for (int g = 0; g < NP; g++) begin
      found = 1'b0;
      for (int c = 0; c < NP; c++)
        if (!gu[g] && !found && !cu[c] && m_code[c] == m_guess[g]) begin
          cu[c] = 1'b1; found = 1'b1; pt++;
        end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_idle = 1'b1; m_over = 1'b0; m_win = 1'b0;
    m_turn = 0; m_hsel = 0; m_cursor = 0;
    for (int p = 0; p < NP; p++) m_guess[p] = 0;
    for (int t = 0; t < MT; t++) begin h_g[t] = 0; h_e[t] = 0; h_p[t] = 0; end
  endtask

  task automatic model_btn(input int b);
    if (m_idle) return;
    if (m_over && b == 0) begin model_clear(); return; end
    if (mode) begin
      if (b == 3 && m_hsel + 1 < m_turn) m_hsel++;
      if (b == 4 && m_hsel > 0) m_hsel--;
    end else if (!m_over) begin
      case (b)
        1: m_cursor = (m_cursor + NP - 1) % NP;
        2: m_cursor = (m_cursor + 1) % NP;
        3: m_guess[m_cursor] = (m_guess[m_cursor] + 1) % NC;
        4: m_guess[m_cursor] = (m_guess[m_cursor] + NC - 1) % NC;
        default: ;
      endcase
    end
  endtask

  // b: 0 select, 1 left, 2 right, 3 up, 4 down
  task automatic press(input int b);
    btn_select = (b == 0); btn_left = (b == 1); btn_right = (b == 2);
    btn_up = (b == 3); btn_down = (b == 4);
    tick();
    btn_select = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
    model_btn(b);
  endtask

  task automatic check_all(input string t);
    chk($sformatf("%s.guess", t), int'(guess_out), packg());
    chk($sformatf("%s.cursor", t), int'(cursor), m_cursor);
    chk($sformatf("%s.hist_sel", t), int'(hist_sel), m_hsel);
    chk($sformatf("%s.turn", t), int'(turn_count), m_turn);
    chk($sformatf("%s.busy", t), int'(busy), 0);
    chk($sformatf("%s.game_over", t), int'(game_over), int'(m_over));
    chk($sformatf("%s.win", t), int'(win), int'(m_win));
    chk($sformatf("%s.hist_guess", t), int'(hist_guess), h_g[m_hsel]);
    chk($sformatf("%s.hist_exact", t), int'(hist_exact), h_e[m_hsel]);
    chk($sformatf("%s.hist_partial", t), int'(hist_partial), h_p[m_hsel]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic load_code(input logic [GW-1:0] c);
    code_in = c; code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
    for (int p = 0; p < NP; p++) m_code[p] = (int'(c) >> (CW * p)) & (NC - 1);
    m_idle = 1'b0;
  endtask

  task automatic set_guess(input logic [GW-1:0] tgt);
    for (int p = 0; p < NP; p++) begin
      int want, delta;
      want = (int'(tgt) >> (CW * p)) & (NC - 1);
      while (m_cursor != p) press(2);
      delta = (want - m_guess[p] + NC) % NC;
      if (delta <= NC / 2) repeat (delta) press(3);
      else repeat (NC - delta) press(4);
    end
    chk("set_guess", int'(guess_out), int'(tgt));
  endtask

  task automatic commit();
    int cnt, e, pt;
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin cnt++; tick(); end
    chk("busy_cycles", cnt, NC + 1);
    score(e, pt);
    h_g[m_turn] = packg(); h_e[m_turn] = e; h_p[m_turn] = pt;
    m_turn++;
    m_hsel = m_turn - 1;
    if (e == NP) begin m_over = 1'b1; m_win = 1'b1; end
    else if (m_turn == MT) m_over = 1'b1;
    check_all("commit");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b1, pk(3,1,4,1), pk(3,1,4,1), 4, 0, 1'b1};
    vt[1] = '{1'b1, pk(1,2,3,4), pk(4,3,2,1), 0, 4, 1'b0};
    vt[2] = '{1'b0, pk(1,2,3,4), pk(1,1,1,1), 1, 0, 1'b0};
    vt[3] = '{1'b1, pk(0,0,7,7), pk(7,7,0,0), 0, 4, 1'b0};
    vt[4] = '{1'b1, pk(5,5,5,2), pk(5,2,6,6), 1, 1, 1'b0};
    vt[5] = '{1'b1, pk(0,0,0,0), pk(7,7,7,7), 0, 0, 1'b0};
    vt[6] = '{1'b1, pk(6,1,6,1), pk(1,6,6,0), 1, 2, 1'b0};

    do_reset();
    check_all("reset");
    press(2); press(3);
    check_all("idle_btn");

    for (int i = 0; i < 7; i++) begin
      if (vt[i].fresh) begin do_reset(); load_code(vt[i].code); end
      set_guess(vt[i].guess);
      commit();
      chk($sformatf("vec%0d.exact", i), int'(hist_exact), vt[i].ex);
      chk($sformatf("vec%0d.partial", i), int'(hist_partial), vt[i].pa);
      chk($sformatf("vec%0d.win", i), int'(win), int'(vt[i].won));
      chk($sformatf("vec%0d.over", i), int'(game_over), int'(vt[i].won));
    end

    // Cursor and colour wrap, and button priority
    do_reset();
    load_code(pk(0,0,0,0));
    press(1); chk("left_wrap", int'(cursor), 3);
    press(2); chk("right_wrap", int'(cursor), 0);
    press(4); chk("down_wrap", int'(guess_out), 7);
    press(3); chk("up_wrap", int'(guess_out), 0);
    btn_left = 1'b1; btn_up = 1'b1;
    tick();
    btn_left = 1'b0; btn_up = 1'b0;
    model_btn(1);
    chk("left_up_cursor", int'(cursor), 3);
    check_all("left_up");

    // History navigation after three turns
    do_reset();
    load_code(pk(1,2,3,4));
    set_guess(pk(4,3,2,1)); commit();
    set_guess(pk(1,1,1,1)); commit();
    set_guess(pk(0,2,0,4)); commit();
    mode = 1'b1;
    repeat (5) begin press(4); check_all("hist_down"); end
    chk("hist_down_floor", int'(hist_sel), 0);
    repeat (5) begin press(3); check_all("hist_up"); end
    chk("hist_up_ceiling", int'(hist_sel), 2);
    press(1); press(2); press(0);
    check_all("mode1_entry_btns");
    mode = 1'b0;

    // Reset during the fourth scoring cycle
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    chk("abort.busy_before", int'(busy), 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check_all("abort");
    press(3);
    check_all("abort_idle");

    // Random games against the model; game 0 is forced to lose, game 1 wins on turn 4
    for (int g = 0; g < 5; g++) begin
      logic [GW-1:0] code, gs;
      do_reset();
      code = GW'($urandom_range(0, 4095));
      load_code(code);
      for (int t = 0; t < MT && !m_over; t++) begin
        gs = GW'($urandom_range(0, 4095));
        if (g == 1 && t == 3) gs = code;
        else if (gs == code) gs = gs ^ GW'(1);
        set_guess(gs);
        commit();
      end
      chk($sformatf("game%0d.over", g), int'(game_over), 1);
      mode = 1'b1;
      press(4);
      check_all("over_nav");
      mode = 1'b0;
      press(0);
      check_all("restart");
      press(3);
      check_all("restart_idle");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
